// File: rtl/score_tally.sv
// score_tally
//
// Purpose:
//   Turns the per-cookie "eaten" flags into a BCD score and a count of
//   remaining cookies. The flag vector is scanned one cookie per clock, so a
//   single 4-digit BCD adder serves every cookie. A shadow "seen" vector makes
//   sure each cookie is credited only once per level. When the last cookie is
//   credited, the level-complete flag is set.
//
// Ports:
//   Clk               in   system clock
//   Reset             in   asynchronous, active-high reset
//   Eaten             in   [N_COOKIES] bit i high once cookie i has been eaten (level)
//   Clear_level       in   single-cycle pulse: a new maze is loaded
//   Score_bcd         out  [16] four BCD digits, [15:12] is thousands
//   Remaining         out  [11] cookies not yet credited in this level
//   Eat_pulse         out  one-cycle pulse for each credited cookie
//   Level_clear       out  sticky, set when Remaining reaches zero
//   Level_clear_pulse out  one-cycle pulse on the credit that empties the level

`timescale 1ns/1ps

module score_tally #(
    parameter int         N_COOKIES  = 64,
    parameter logic [7:0] POINTS_BCD = 8'h10,
    parameter int         IDX_W      = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_COOKIES-1:0] Eaten,
    input  logic                 Clear_level,
    output logic [15:0]          Score_bcd,
    output logic [10:0]          Remaining,
    output logic                 Eat_pulse,
    output logic                 Level_clear,
    output logic                 Level_clear_pulse
);

    localparam logic [10:0]      FULL_COUNT  = 11'(N_COOKIES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_COOKIES - 1);
    localparam logic [15:0]      POINTS_WIDE = {8'h00, POINTS_BCD};
    localparam logic [15:0]      SCORE_MAX   = 16'h9999;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_COOKIES-1:0] seen_q, seen_d;
    logic [15:0]          score_q, score_d;
    logic [10:0]          remaining_q, remaining_d;
    logic                 eatPulse_q, eatPulse_d;
    logic                 levelClear_q, levelClear_d;
    logic                 levelClearPulse_q, levelClearPulse_d;

    logic [N_COOKIES-1:0] idxOneHot;
    logic                 curEaten;
    logic                 curSeen;
    logic                 credit;
    logic [16:0]          bcdSum;

    // Decimal-correct add of two 4-digit BCD numbers. Bit 16 is the carry out
    // of the thousands digit, i.e. the result no longer fits in 9999.
    function automatic logic [16:0] bcdAdd(input logic [15:0] a, input logic [15:0] b);
        logic        carry;
        logic [4:0]  digitSum;
        logic [15:0] result;
        carry  = 1'b0;
        result = '0;
        for (int d = 0; d < 4; d++) begin
            digitSum = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0000, carry};
            if (digitSum > 5'd9) begin
                digitSum = digitSum - 5'd10;
                carry    = 1'b1;
            end else begin
                carry    = 1'b0;
            end
            result[4*d +: 4] = digitSum[3:0];
        end
        return {carry, result};
    endfunction

    // A one-hot decode of the scan index selects the current cookie without a
    // variable bit-select, so any N_COOKIES/IDX_W pairing stays width-clean.
    always_comb begin
        idxOneHot = '0;
        for (int i = 0; i < N_COOKIES; i++) begin
            idxOneHot[i] = (idx_q == IDX_W'(i));
        end
    end

    assign curEaten = |(Eaten & idxOneHot);
    assign curSeen  = |(seen_q & idxOneHot);
    assign credit   = curEaten & ~curSeen & ~levelClear_q;
    assign bcdSum   = bcdAdd(score_q, POINTS_WIDE);

    // Next-state logic. Clear_level wins over a credit that lands in the same
    // cycle. That credit is dropped, and the cookie is picked up again on the
    // next sweep if its flag is still high.
    always_comb begin
        idx_d             = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        seen_d            = seen_q;
        score_d           = score_q;
        remaining_d       = remaining_q;
        levelClear_d      = levelClear_q;
        eatPulse_d        = 1'b0;
        levelClearPulse_d = 1'b0;

        if (Clear_level) begin
            seen_d       = '0;
            remaining_d  = FULL_COUNT;
            levelClear_d = 1'b0;
            idx_d        = '0;
        end else if (credit) begin
            seen_d      = seen_q | idxOneHot;
            score_d     = bcdSum[16] ? SCORE_MAX : bcdSum[15:0];
            remaining_d = remaining_q - 11'd1;
            eatPulse_d  = 1'b1;
            if (remaining_q == 11'd1) begin
                levelClear_d      = 1'b1;
                levelClearPulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q             <= '0;
            seen_q            <= '0;
            score_q           <= '0;
            remaining_q       <= FULL_COUNT;
            eatPulse_q        <= 1'b0;
            levelClear_q      <= 1'b0;
            levelClearPulse_q <= 1'b0;
        end else begin
            idx_q             <= idx_d;
            seen_q            <= seen_d;
            score_q           <= score_d;
            remaining_q       <= remaining_d;
            eatPulse_q        <= eatPulse_d;
            levelClear_q      <= levelClear_d;
            levelClearPulse_q <= levelClearPulse_d;
        end
    end

    assign Score_bcd         = score_q;
    assign Remaining         = remaining_q;
    assign Eat_pulse         = eatPulse_q;
    assign Level_clear       = levelClear_q;
    assign Level_clear_pulse = levelClearPulse_q;

endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally
//
// Purpose:
//   Drives two score_tally instances (8 cookies; 10 and 5 points per cookie)
//   with the same eaten and clear stimulus. It compares every cycle against a
//   reference model that keeps the score as an ordinary decimal integer and
//   the credited cookies as a plain bit array.
//
// Ports: none (top-level bench).

`timescale 1ns/1ps

module tb_score_tally;

    localparam int N = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N-1:0] Eaten;
    logic         Clear_level;

    logic [15:0] scoreTen, scoreFive;
    logic [10:0] remTen, remFive;
    logic        eatTen, eatFive, lcTen, lcFive, lcpTen, lcpFive;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int scanPos;
    bit credited [N];
    int scoreA;
    int scoreB;
    int remaining;
    bit levelDone;
    bit expEat;
    bit expLcp;

    always #5 Clk = ~Clk;

    score_tally #(.N_COOKIES(N), .POINTS_BCD(8'h10), .IDX_W(10)) dutTen (
        .Clk(Clk), .Reset(Reset), .Eaten(Eaten), .Clear_level(Clear_level),
        .Score_bcd(scoreTen), .Remaining(remTen), .Eat_pulse(eatTen),
        .Level_clear(lcTen), .Level_clear_pulse(lcpTen)
    );

    score_tally #(.N_COOKIES(N), .POINTS_BCD(8'h05), .IDX_W(10)) dutFive (
        .Clk(Clk), .Reset(Reset), .Eaten(Eaten), .Clear_level(Clear_level),
        .Score_bcd(scoreFive), .Remaining(remFive), .Eat_pulse(eatFive),
        .Level_clear(lcFive), .Level_clear_pulse(lcpFive)
    );

    // Every comparison goes through this task.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic modelReset();
        scanPos   = 0;
        scoreA    = 0;
        scoreB    = 0;
        remaining = N;
        levelDone = 1'b0;
        expEat    = 1'b0;
        expLcp    = 1'b0;
        for (int i = 0; i < N; i++) credited[i] = 1'b0;
    endtask

    // One clock of game behaviour: look at the cookie under the scan pointer,
    // credit it if it is newly eaten, then move the pointer on.
    task automatic modelStep(input logic [N-1:0] e, input bit clr);
        expEat = 1'b0;
        expLcp = 1'b0;
        if (clr) begin
            for (int i = 0; i < N; i++) credited[i] = 1'b0;
            remaining = N;
            levelDone = 1'b0;
            scanPos   = 0;
        end else begin
            if (e[scanPos] && !credited[scanPos] && !levelDone) begin
                credited[scanPos] = 1'b1;
                scoreA    = (scoreA + 10 > 9999) ? 9999 : scoreA + 10;
                scoreB    = (scoreB + 5 > 9999) ? 9999 : scoreB + 5;
                remaining = remaining - 1;
                expEat    = 1'b1;
                if (remaining == 0) begin
                    levelDone = 1'b1;
                    expLcp    = 1'b1;
                end
            end
            scanPos = (scanPos + 1) % N;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "/scoreTen"},  {16'h0, scoreTen},  {16'h0, toBcd(scoreA)});
        checkOutput({tag, "/scoreFive"}, {16'h0, scoreFive}, {16'h0, toBcd(scoreB)});
        checkOutput({tag, "/statusTen"}, {18'h0, remTen, eatTen, lcTen, lcpTen},
                    {18'h0, 11'(remaining), expEat, levelDone, expLcp});
        checkOutput({tag, "/statusFive"}, {18'h0, remFive, eatFive, lcFive, lcpFive},
                    {18'h0, 11'(remaining), expEat, levelDone, expLcp});
    endtask

    // One clock: inputs are held across the rising edge, and outputs are
    // sampled 1 ns after it.
    task automatic applyStimulus(input string tag, input logic [N-1:0] e, input bit clr);
        Eaten       = e;
        Clear_level = clr;
        @(posedge Clk);
        modelStep(e, clr);
        #1;
        compareAll(tag);
    endtask

    // Raise reset between edges, check the outputs before the next edge, and
    // release reset well clear of the following rising edge.
    task automatic asyncReset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        modelReset();
        compareAll(tag);
        @(negedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] e;
        int eatCount;
        int lcpCount;
        int lcpWithEat;
        int firstPulse;
        int order [N-1];
        int k;
        int tmp;

        Reset       = 1'b1;
        Eaten       = '0;
        Clear_level = 1'b0;
        modelReset();
        #12;
        compareAll("reset");
        Reset = 1'b0;

        // Idle: no cookies eaten.
        for (int c = 0; c < 20; c++) applyStimulus("idle", '0, 1'b0);

        // Single cookie 5: credited once, six edges after it is raised at idx 0.
        asyncReset("rst0");
        eatCount   = 0;
        firstPulse = -1;
        for (int c = 1; c <= 4 * N; c++) begin
            applyStimulus("single", 8'h20, 1'b0);
            if (eatTen) begin
                eatCount++;
                if (firstPulse < 0) firstPulse = c;
            end
        end
        checkOutput("singleCount", 32'(eatCount), 32'd1);
        checkOutput("singleLatency", 32'(firstPulse), 32'd6);
        checkOutput("singleScore", {16'h0, scoreTen}, 32'h0010);
        checkOutput("singleRemaining", {21'h0, remTen}, 32'd7);

        // Raise the other bits one at a time, in random order.
        k = 0;
        for (int i = 0; i < N; i++) if (i != 5) begin order[k] = i; k++; end
        for (int i = N - 2; i > 0; i--) begin
            k = int'($urandom_range(0, i));
            tmp = order[i]; order[i] = order[k]; order[k] = tmp;
        end
        e          = 8'h20;
        lcpCount   = 0;
        lcpWithEat = 0;
        for (int b = 0; b < N - 1; b++) begin
            e[order[b]] = 1'b1;
            for (int c = 0; c < N; c++) begin
                applyStimulus("fill", e, 1'b0);
                if (eatTen) eatCount++;
                if (lcpTen) lcpCount++;
                if (lcpTen && eatTen) lcpWithEat++;
            end
        end
        checkOutput("fillPulses", 32'(eatCount), 32'd8);
        checkOutput("fillScoreTen", {16'h0, scoreTen}, 32'h0080);
        checkOutput("fillScoreFive", {16'h0, scoreFive}, 32'h0040);
        checkOutput("fillRemaining", {21'h0, remTen}, 32'd0);
        checkOutput("fillLevelClear", {31'h0, lcTen}, 32'd1);
        checkOutput("fillLcpCount", 32'(lcpCount), 32'd1);
        checkOutput("fillLcpWithEat", 32'(lcpWithEat), 32'd1);

        // Clear_level, then Clear_level again while cookie 0 is pending.
        applyStimulus("clear1", 8'hFF, 1'b1);
        applyStimulus("clear2", 8'hFF, 1'b1);
        checkOutput("clearNoEat", {31'h0, eatTen}, 32'd0);
        checkOutput("clearRemaining", {21'h0, remTen}, 32'd8);
        checkOutput("clearLevel", {31'h0, lcTen}, 32'd0);
        checkOutput("clearScore", {16'h0, scoreTen}, 32'h0080);
        for (int c = 0; c < N; c++) applyStimulus("recredit", 8'hFF, 1'b0);
        checkOutput("recreditScore", {16'h0, scoreTen}, 32'h0160);
        checkOutput("recreditRemaining", {21'h0, remTen}, 32'd0);

        // Random traffic: bits rise and fall, with occasional clears and resets.
        e = '0;
        for (int c = 0; c < 1500; c++) begin
            logic clr;
            k = int'($urandom_range(0, 99));
            if (k < 20) e[$urandom_range(0, N - 1)] = 1'b1;
            else if (k < 25) e[$urandom_range(0, N - 1)] = 1'b0;
            clr = ($urandom_range(0, 59) == 0);
            if (clr && $urandom_range(0, 1) == 1) e = '0;
            if ($urandom_range(0, 199) == 0) asyncReset("randRst");
            else applyStimulus("random", e, clr);
        end

        // Push the score past 9999: all cookies eaten, with a new level every 9 cycles.
        for (int c = 0; c < 1400; c++) applyStimulus("saturate", 8'hFF, (c % 9) == 0);
        checkOutput("saturateTen", {16'h0, scoreTen}, 32'h9999);

        // Reset mid-sweep; scanning restarts at cookie 0 after release.
        for (int c = 0; c < 3; c++) applyStimulus("preRst", 8'h0F, 1'b0);
        asyncReset("midRst");
        applyStimulus("postRst", 8'hFF, 1'b0);
        checkOutput("postRstEat", {31'h0, eatTen}, 32'd1);
        for (int c = 0; c < N; c++) applyStimulus("postRstSweep", 8'hFF, 1'b0);
        checkOutput("postRstScore", {16'h0, scoreTen}, 32'h0080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
